// File: rtl/riscv_regfile_pkg.sv
// Shared types and defaults for the multi-port integer register file.
// Build option: RISCV_REGFILE_BYPASS_EN enables same-cycle write forwarding.
package riscv_regfile_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_t;

  localparam int XLEN_D = 32;
  localparam int NREG_D = 32;
  localparam int AW_D   = $clog2(NREG_D);

  function automatic int aw_of(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/riscv_rf_scoreboard.sv
// Per-register pending bits: set at issue, cleared at writeback.
// A same-cycle set and clear of one register leaves it pending.
module riscv_rf_scoreboard
  import riscv_regfile_pkg::*;
#(
  parameter int NREG = NREG_D,
  parameter int NRP  = 2,
  parameter int NWP  = 1,
  parameter int AW   = aw_of(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWP-1:0]    clr_en,
  input  logic [NWP*AW-1:0] clr_addr,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic [NRP*AW-1:0] ra,
  output logic [NRP-1:0]    pend
);

  logic [NREG-1:0] bits;
  logic [NREG-1:0] nxt;

  always_comb begin
    nxt = bits;
    for (int k = 0; k < NWP; k++) begin
      if (clr_en[k]) nxt[clr_addr[k*AW +: AW]] = 1'b0;
    end
    // the new producer supersedes any write landing this cycle
    if (set_en) nxt[set_addr] = 1'b1;
    nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) bits <= '0;
    else     bits <= nxt;
  end

  for (genvar j = 0; j < NRP; j++) begin : g_rp
    assign pend[j] = bits[ra[j*AW +: AW]];
  end

endmodule

// File: rtl/riscv_regfile_mp.sv
// Multi-port register file with reset-driven clear walk and scoreboard.
// Build option: RISCV_REGFILE_BYPASS_EN forwards write data to reads.
module riscv_regfile_mp
  import riscv_regfile_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREG = NREG_D,
  parameter int NRP  = 2,
  parameter int NWP  = 1,
  localparam int AW  = aw_of(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWP-1:0]      we,
  input  logic [NWP*AW-1:0]   wa,
  input  logic [NWP*XLEN-1:0] wd,
  input  logic [NRP*AW-1:0]   ra,
  output logic [NRP*XLEN-1:0] rd,
  output logic [NRP-1:0]      rd_pend,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  output logic                ready
);

  rf_state_t       state;
  logic [AW-1:0]   ptr;
  logic            live;
  logic [NWP-1:0]  wr_en;
  logic [NRP-1:0]  pend_raw;
  logic [XLEN-1:0] rf [NREG];

  assign ready = (state == RF_READY);
  assign live  = ready && !rst;

  for (genvar k = 0; k < NWP; k++) begin : g_wp
    assign wr_en[k] = live && we[k] && (wa[k*AW +: AW] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_CLEAR;
      ptr   <= AW'(1);
    end else if (state == RF_CLEAR) begin
      if (ptr == AW'(NREG - 1)) state <= RF_READY;
      else                      ptr   <= ptr + 1'b1;
    end
  end

  // later ports overwrite earlier ones on an address clash
  always_ff @(posedge clk) begin
    if (!rst && state == RF_CLEAR) begin
      rf[ptr] <= '0;
    end else begin
      for (int k = 0; k < NWP; k++) begin
        if (wr_en[k]) rf[wa[k*AW +: AW]] <= wd[k*XLEN +: XLEN];
      end
    end
  end

  riscv_rf_scoreboard #(
    .NREG(NREG),
    .NRP (NRP),
    .NWP (NWP),
    .AW  (AW)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .clr_en  (wr_en),
    .clr_addr(wa),
    .set_en  (live && iss_valid),
    .set_addr(iss_addr),
    .ra      (ra),
    .pend    (pend_raw)
  );

  always_comb begin
    rd      = '0;
    rd_pend = '0;
    for (int j = 0; j < NRP; j++) begin
      if (ready && ra[j*AW +: AW] != '0) begin
        rd[j*XLEN +: XLEN] = rf[ra[j*AW +: AW]];
        rd_pend[j]         = pend_raw[j];
      end
`ifdef RISCV_REGFILE_BYPASS_EN
      for (int k = 0; k < NWP; k++) begin
        if (wr_en[k] && wa[k*AW +: AW] == ra[j*AW +: AW]) begin
          rd[j*XLEN +: XLEN] = wd[k*XLEN +: XLEN];
          rd_pend[j] = iss_valid && (iss_addr == ra[j*AW +: AW]);
        end
      end
`endif
    end
  end

endmodule

// File: doc/riscv_regfile_mp.md
# riscv_regfile_mp

Parametrised multi-port integer register file for the RISC-V core, successor to the single-write, dual-read register file. It adds configurable width, depth and port counts, a hardware clear sequencer driven by synchronous reset, and a per-register pending (scoreboard) bit set at issue and cleared at writeback. It sits between decode (read and issue) and writeback (write ports).

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, ≥4); AW = $clog2(NREG)
- NRP, 2, number of read ports (1..4)
- NWP, 1, number of write ports (1..2)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- we  in  NWP  write enable per write port
- wa  in  NWP*AW  write address; port k at [k*AW +: AW]
- wd  in  NWP*XLEN  write data; port k at [k*XLEN +: XLEN]
- ra  in  NRP*AW  read address per read port
- rd  out  NRP*XLEN  read data per read port (combinational)
- rd_pend  out  NRP  pending bit of the register addressed by each read port
- iss_valid  in  1  issue: mark iss_addr pending
- iss_addr  in  AW  destination register of the issuing instruction
- ready  out  1  high when clear sequence is complete and the file is usable

## Operation
- Single clock, clk; synchronous active-high reset, rst.
- Register 0 is hardwired: reads return 0, rd_pend returns 0, writes and issues to address 0 are ignored.
- FSM states: CLEAR, READY.
  - rst=1: state←CLEAR, ptr←1, all pending bits←0.
  - CLEAR: each cycle with rst=0: rf[ptr]←0, ptr←ptr+1; on ptr==NREG-1 write, state←READY.
  - READY: normal operation; it is left only via rst.
- During CLEAR, including while rst is held, ready=0, all rd=0, all rd_pend=0, and we and iss_valid are ignored.
- Write: in READY, on posedge, rf[wa_k]←wd_k for each k with we_k=1 and wa_k≠0. If both ports target the same address, port NWP-1 wins.
- Pending: a write (we_k, wa_k≠0) clears pend[wa_k]. iss_valid with iss_addr≠0 sets pend[iss_addr]. Set and clear of the same register in the same cycle leave the bit set, because a new producer supersedes the old one.
- Reads are combinational from array state, plus forwarding when RISCV_REGFILE_BYPASS_EN is defined.
- Arithmetic: no arithmetic on data; ptr is AW bits and never wraps past NREG-1.

## Timing
- Reset values: ready=0, rd=0, rd_pend=0, ptr=1, pend=0.
- ready rises NREG-1 cycles after the first posedge with rst=0 (31 cycles at NREG=32).
- Asserting rst mid-clear or in READY restarts the sequence from ptr=1 on the next posedge. Array contents are overwritten only by the walk.
- Write-to-read latency without bypass: write at edge N is visible on rd after edge N, i.e. 1 cycle.
- Issue-to-pending latency: rd_pend reflects iss_valid after the next posedge.

## Configuration
- RISCV_REGFILE_BYPASS_EN defined: in READY, if any we_k=1 with wa_k==ra_j≠0, rd_j=wd_k combinationally in the same cycle, with the highest-indexed matching port winning. rd_pend_j is forced to 0 in that case unless iss_valid targets the same register.
- Not defined: rd and rd_pend reflect registered state only. A same-cycle write is not visible until the next cycle.

## Structure
- Package riscv_regfile_pkg:
  - state enum rf_state_t {RF_CLEAR, RF_READY}
  - default parameter constants (XLEN_D=32, NREG_D=32)
  - localparam helper for AW
- Sub-module riscv_rf_scoreboard:
  - holds the NREG pending bits with set/clear/priority logic
  - exposes NRP lookup ports
  - cleared by rst
- The top level holds the array, clear FSM, write-port priority and bypass muxing.

## Test plan
- Reset and clear: rst high 3 cycles, then low. ready=0 for exactly 31 cycles, then 1; reads of x1..x31 return 0.
- Basic write/read: write x5←0xDEADBEEF. Without bypass, rd0=0 in the same cycle and 0xDEADBEEF in the next; with RISCV_REGFILE_BYPASS_EN, 0xDEADBEEF in the same cycle.
- x0 and port conflict:
  - write x0←0xFFFFFFFF: read x0 = 0.
  - NWP=2, both ports write x7 (0x11, 0x22): x7 = 0x22.
- Scoreboard:
  - issue x9: next cycle rd_pend=1.
  - write x9: pending clears.
  - same-cycle issue x9 and write x9: pending stays 1.
- Mid-operation reset: after writing x3←0x1234, assert rst 1 cycle. ready drops, the clear reruns, and x3 reads 0 once ready=1.
- Writes during CLEAR: we=1 to x4←0xAA at cycle 5 of the walk. The write is ignored and x4 = 0 after ready.
